// File: rtl/pb_debounce_sched.sv
// Round-robin debouncer: one shared tick divider and stable-tick counter serve N_BTN active-low buttons.
// Optional macro PB_RELEASE_PULSE_EN adds a btn_release pulse output for 1->0 commits.
module pb_debounce_sched #(
    parameter int CLK         = 50000000,
    parameter int TICK_HZ     = 1000,
    parameter int N_BTN       = 4,
    parameter int DEBOUNCE_MS = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] pb_n,
    output logic [N_BTN-1:0] btn_state,
    output logic [N_BTN-1:0] btn_press,
    output logic             busy,
    output logic [2:0]       owner
`ifdef PB_RELEASE_PULSE_EN
    ,
    output logic [N_BTN-1:0] btn_release
`endif
);

    // state  | meaning
    // SCAN   | timer free, round-robin search for a button whose level disagrees
    // COUNT  | timer granted to owner_q, counting stable ticks
    // COMMIT | one clk: latch the confirmed level into btn_state
    typedef enum logic [1:0] {SCAN, COUNT, COMMIT} state_t;

    localparam int DIV = CLK / TICK_HZ;
    localparam int PW  = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int DW  = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [7:0]    CNT_LAST = 8'(DEBOUNCE_MS);
    localparam logic [PW-1:0] IDX_LAST = PW'(N_BTN - 1);

    state_t            state_q, state_d;
    logic [N_BTN-1:0]  sync_a, sync_b, pb_s;
    logic [PW-1:0]     ptr_q, owner_q;
    logic [DW-1:0]     div_q;
    logic [7:0]        cnt_q;
    logic              cand_diff, own_diff, tick, cnt_done;

    function automatic logic [PW-1:0] idx_inc(input logic [PW-1:0] i);
        return (i == IDX_LAST) ? '0 : i + PW'(1);
    endfunction

    // Synchronizer resets to the released level so no phantom change is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= pb_n;
            sync_b <= sync_a;
        end
    end

    assign pb_s      = ~sync_b;
    assign cand_diff = pb_s[ptr_q] != btn_state[ptr_q];
    assign own_diff  = pb_s[owner_q] != btn_state[owner_q];
    assign tick      = div_q == DIV_LAST;
    assign cnt_done  = tick && ((cnt_q + 8'd1) == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SCAN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN:    if (cand_diff) state_d = COUNT;
            COUNT: begin
                if (!own_diff)     state_d = SCAN;
                else if (cnt_done) state_d = COMMIT;
            end
            COMMIT:  state_d = SCAN;
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        busy = state_q != SCAN;
        owner = '0;
        owner[PW-1:0] = owner_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            owner_q     <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            btn_state   <= '0;
            btn_press   <= '0;
`ifdef PB_RELEASE_PULSE_EN
            btn_release <= '0;
`endif
        end else begin
            btn_press   <= '0;
`ifdef PB_RELEASE_PULSE_EN
            btn_release <= '0;
`endif
            case (state_q)
                SCAN: begin
                    if (cand_diff) begin
                        owner_q <= ptr_q;
                        div_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        ptr_q <= idx_inc(ptr_q);
                    end
                end
                COUNT: begin
                    // A glitch back to the debounced level aborts; abort wins over a tick.
                    if (!own_diff) begin
                        ptr_q <= idx_inc(owner_q);
                    end else begin
                        div_q <= tick ? '0 : div_q + DW'(1);
                        if (tick) cnt_q <= cnt_q + 8'd1;
                    end
                end
                COMMIT: begin
                    btn_state[owner_q]   <= pb_s[owner_q];
                    btn_press[owner_q]   <= pb_s[owner_q] & ~btn_state[owner_q];
`ifdef PB_RELEASE_PULSE_EN
                    btn_release[owner_q] <= ~pb_s[owner_q] & btn_state[owner_q];
`endif
                    ptr_q <= idx_inc(owner_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pb_debounce_sched.sv
// Bench for pb_debounce_sched: a vector table, timing sequences for the corner cases, and a random phase,
// all compared every clk against an elapsed-clock reference model of the round-robin debounce rules.
module tb_pb_debounce_sched;

    localparam int NB  = 4;
    localparam int DIV = 10;
    localparam int DBM = 4;

    logic          clk;
    logic          rst;
    logic [NB-1:0] pb_n;
    logic [NB-1:0] btn_state;
    logic [NB-1:0] btn_press;
    logic          busy;
    logic [2:0]    owner;
`ifdef PB_RELEASE_PULSE_EN
    logic [NB-1:0] btn_release;
`endif

    pb_debounce_sched #(
        .CLK(1000), .TICK_HZ(100), .N_BTN(NB), .DEBOUNCE_MS(DBM)
    ) dut (
        .clk(clk), .rst(rst), .pb_n(pb_n),
        .btn_state(btn_state), .btn_press(btn_press),
        .busy(busy), .owner(owner)
`ifdef PB_RELEASE_PULSE_EN
        , .btn_release(btn_release)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int press_seen = 0;
    int rel_seen = 0;

    // Reference model: synchronizer history, debounced levels, scheduler in elapsed clocks.
    logic [NB-1:0] m_sync1, m_sync2, m_state, m_press, m_rel;
    bit            m_busy, m_commit;
    int            m_owner, m_ptr, m_elapsed;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync1 = '1; m_sync2 = '1;
        m_state = '0; m_press = '0; m_rel = '0;
        m_busy = 0; m_commit = 0;
        m_owner = 0; m_ptr = 0; m_elapsed = 0;
    endtask

    task automatic model_step();
        logic [NB-1:0] pbs;
        pbs = ~m_sync2;
        m_press = '0;
        m_rel = '0;
        if (m_commit) begin
            if (pbs[m_owner] != m_state[m_owner]) begin
                if (pbs[m_owner]) m_press[m_owner] = 1'b1;
                else              m_rel[m_owner] = 1'b1;
                m_state[m_owner] = pbs[m_owner];
            end
            m_commit = 0;
            m_busy = 0;
            m_ptr = (m_owner + 1) % NB;
        end else if (m_busy) begin
            if (pbs[m_owner] == m_state[m_owner]) begin
                m_busy = 0;
                m_ptr = (m_owner + 1) % NB;
            end else begin
                m_elapsed++;
                if (m_elapsed == DBM * DIV) m_commit = 1;
            end
        end else if (pbs[m_ptr] != m_state[m_ptr]) begin
            m_busy = 1;
            m_owner = m_ptr;
            m_elapsed = 0;
        end else begin
            m_ptr = (m_ptr + 1) % NB;
        end
        m_sync2 = m_sync1;
        m_sync1 = pb_n;
    endtask

    task automatic check_model();
        chk("btn_state", int'(btn_state), int'(m_state));
        chk("btn_press", int'(btn_press), int'(m_press));
        chk("busy", int'(busy), int'(m_busy));
        chk("owner", int'(owner), m_owner);
`ifdef PB_RELEASE_PULSE_EN
        chk("btn_release", int'(btn_release), int'(m_rel));
`endif
    endtask

    // Every task below starts and ends at a negedge.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        check_model();
        press_seen += $countones(btn_press);
`ifdef PB_RELEASE_PULSE_EN
        rel_seen += $countones(btn_release);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_model();
        repeat (3) cycle();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int idx, input int budget, output int w, output bit ok);
        w = 0; ok = 0;
        while (w < budget && !ok) begin
            cycle();
            w++;
            if (busy && (idx < 0 || int'(owner) == idx)) ok = 1;
        end
    endtask

    task automatic wait_press(input int idx, input int budget, output int w, output bit ok);
        w = 0; ok = 0;
        while (w < budget && !ok) begin
            cycle();
            w++;
            if (btn_press[idx]) ok = 1;
        end
    endtask

    task automatic wait_idle(input int budget, output int w, output bit ok);
        w = 0; ok = 0;
        while (w < budget && !ok) begin
            cycle();
            w++;
            if (!busy) ok = 1;
        end
    endtask

    typedef struct {
        logic [NB-1:0] pb;
        int            hold;
        logic [NB-1:0] exp_state;
        int            exp_press;
        int            exp_rel;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int  w;
        bit  ok;
        int  o;
        int  t;
        bit  done;

        vecs[0] = '{4'hF, 10,  4'h0, 0, 0};
        vecs[1] = '{4'hB, 60,  4'h4, 1, 0};
        vecs[2] = '{4'hA, 60,  4'h5, 1, 0};
        vecs[3] = '{4'hF, 120, 4'h0, 0, 2};
        vecs[4] = '{4'h6, 120, 4'h9, 2, 0};
        vecs[5] = '{4'h0, 250, 4'hF, 2, 0};
        vecs[6] = '{4'hF, 250, 4'h0, 0, 4};

        rst = 1'b1;
        pb_n = '1;
        model_reset();
        @(negedge clk);
        do_reset();
        chk("reset_state", int'(btn_state), 0);
        chk("reset_busy", int'(busy), 0);

        foreach (vecs[i]) begin
            pb_n = vecs[i].pb;
            press_seen = 0;
            rel_seen = 0;
            repeat (vecs[i].hold) cycle();
            chk($sformatf("vec%0d_state", i), int'(btn_state), int'(vecs[i].exp_state));
            chk($sformatf("vec%0d_presses", i), press_seen, vecs[i].exp_press);
`ifdef PB_RELEASE_PULSE_EN
            chk($sformatf("vec%0d_releases", i), rel_seen, vecs[i].exp_rel);
`endif
        end

        // Clean press on button 2.
        do_reset();
        repeat (5) cycle();
        pb_n = 4'b1011;
        wait_grant(2, 10, w, ok);
        chk("clean_grant_seen", int'(ok), 1);
        chk("clean_grant_in_6", int'(w <= 6), 1);
        wait_press(2, 50, w, ok);
        chk("clean_commit_lat", w, 41);
        chk("clean_state2", int'(btn_state[2]), 1);
        cycle();
        chk("clean_press_width", int'(btn_press[2]), 0);

        // Bounce on button 1: abort, then a regrant after scanning 2,3,0,1.
        do_reset();
        repeat (4) cycle();
        pb_n = 4'b1101;
        press_seen = 0;
        done = 0;
        for (int k = 0; k < 25; k++) begin
            cycle();
            if (busy && owner == 3'd1) done = 1;
        end
        chk("bounce_first_grant", int'(done), 1);
        pb_n[1] = 1'b1;
        cycle();
        pb_n[1] = 1'b0;
        wait_idle(5, w, ok);
        chk("bounce_abort", int'(ok), 1);
        chk("bounce_no_press", press_seen, 0);
        wait_grant(1, 10, w, ok);
        chk("bounce_regrant_lat", w, 4);
        wait_press(1, 50, w, ok);
        chk("bounce_commit_lat", w, 41);

        // Simultaneous press of 0 and 3, timed so the scan is at ptr=0.
        do_reset();
        cycle();
        cycle();
        pb_n = 4'b0110;
        wait_grant(-1, 10, w, ok);
        chk("simul_first_owner", int'(owner), 0);
        chk("simul_first_lat", w, 3);
        wait_press(0, 50, w, ok);
        chk("simul_commit0_lat", w, 41);
        wait_grant(3, 6, w, ok);
        chk("simul_grant3_lat", w, 3);
        wait_press(3, 50, w, ok);
        chk("simul_commit3_lat", w, 41);

        // Release of button 0 (button 3 stays pressed).
        pb_n = 4'b0111;
        press_seen = 0;
        rel_seen = 0;
        repeat (60) cycle();
        chk("release_state", int'(btn_state), 4'h8);
        chk("release_no_press", press_seen, 0);
`ifdef PB_RELEASE_PULSE_EN
        chk("release_pulses", rel_seen, 1);
`endif

        // Reset in the middle of a COUNT.
        do_reset();
        pb_n = 4'b1110;
        wait_press(0, 60, w, ok);
        chk("rstmid_pre_press", int'(ok), 1);
        pb_n = 4'b0110;
        wait_grant(3, 10, w, ok);
        chk("rstmid_grant3", int'(ok), 1);
        repeat (20) cycle();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_state", int'(btn_state), 0);
        chk("rstmid_press", int'(btn_press), 0);
        repeat (2) cycle();
        rst = 1'b0;
        wait_grant(-1, 10, w, ok);
        chk("rstmid_regrant", int'(ok), 1);
        o = int'(owner);
        wait_press(o, 50, w, ok);
        chk("rstmid_full_debounce", w, 41);

        // Starvation: button 0 toggles every 15 clks, button 1 held.
        do_reset();
        repeat (4) cycle();
        pb_n = 4'b1100;
        t = 0;
        done = 0;
        while (t < 64 && !done) begin
            cycle();
            t++;
            if (btn_state[1]) done = 1;
            if (t % 15 == 0) pb_n[0] = ~pb_n[0];
        end
        chk("starve_btn1_done", int'(done), 1);
        chk("starve_btn0_state", int'(btn_state[0]), 0);

        // Random patterns mixing glitches and long holds.
        pb_n = '1;
        repeat (100) cycle();
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 19) == 0) do_reset();
            pb_n = 4'($urandom);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 20)) cycle();
            else                           repeat ($urandom_range(30, 120)) cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
